// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box lookups, Rcon, GF(2^8) arithmetic and the
// round-key expansion step used by the iterative inverse cipher.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEXP,
    ARK,
    ROUND,
    LAST
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; only the constant multipliers of InvMixColumns use it.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    logic [7:0] m;
    acc = 8'h00;
    x   = a;
    m   = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) acc = acc ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return acc;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         is_last,
  output logic [127:0] state_out
);

  logic [0:15][7:0] s_in;
  logic [0:15][7:0] k;
  logic [0:15][7:0] s_ark;
  logic [0:15][7:0] s_mix;

  assign s_in = state_in;
  assign k    = rk;

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign s_ark[4*c+r] = inv_sbox(s_in[4*((c - r + 4) % 4) + r]) ^ k[4*c+r];
    end

    assign s_mix[4*c+0] = gf_mul(s_ark[4*c+0], 8'h0e) ^ gf_mul(s_ark[4*c+1], 8'h0b) ^
                          gf_mul(s_ark[4*c+2], 8'h0d) ^ gf_mul(s_ark[4*c+3], 8'h09);
    assign s_mix[4*c+1] = gf_mul(s_ark[4*c+0], 8'h09) ^ gf_mul(s_ark[4*c+1], 8'h0e) ^
                          gf_mul(s_ark[4*c+2], 8'h0b) ^ gf_mul(s_ark[4*c+3], 8'h0d);
    assign s_mix[4*c+2] = gf_mul(s_ark[4*c+0], 8'h0d) ^ gf_mul(s_ark[4*c+1], 8'h09) ^
                          gf_mul(s_ark[4*c+2], 8'h0e) ^ gf_mul(s_ark[4*c+3], 8'h0b);
    assign s_mix[4*c+3] = gf_mul(s_ark[4*c+0], 8'h0b) ^ gf_mul(s_ark[4*c+1], 8'h0d) ^
                          gf_mul(s_ark[4*c+2], 8'h09) ^ gf_mul(s_ark[4*c+3], 8'h0e);
  end

  assign state_out = is_last ? s_ark : s_mix;

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with the
// full round-key schedule held locally so a repeated key can skip expansion.
module aes128_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter int KEEP_KEYS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         key_reuse,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [127:0] data_out,
  output logic [3:0]   round_idx
);

  localparam logic [3:0] LAST_KEY = 4'(NR);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] rk [0:10];
  logic         keys_valid;
  logic         reuse_ok;
  logic [127:0] round_out;

  assign reuse_ok  = key_reuse && keys_valid && (KEEP_KEYS != 0);
  assign busy      = ~ready;
  assign round_idx = cnt;

  aes_inv_round u_round (
    .state_in  (st),
    .rk        (rk[cnt]),
    .is_last   (state == LAST),
    .state_out (round_out)
  );

  // cnt doubles as the round-key pointer: it counts up while expanding and
  // down while decrypting, so the same rk[cnt] read serves every round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      st         <= '0;
      rk         <= '{default: '0};
      keys_valid <= 1'b0;
      ready      <= 1'b1;
      valid      <= 1'b0;
      data_out   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            st    <= data_in;
            ready <= 1'b0;
            if (reuse_ok) begin
              cnt   <= LAST_KEY;
              state <= ARK;
            end else begin
              rk[0]      <= key_in;
              keys_valid <= 1'b0;
              cnt        <= 4'd1;
              state      <= KEXP;
            end
          end
        end
        KEXP: begin
          rk[cnt] <= key_expand(rk[cnt - 4'd1], RCON[cnt]);
          if (cnt == LAST_KEY) begin
            keys_valid <= 1'b1;
            state      <= ARK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ARK: begin
          st    <= st ^ rk[LAST_KEY];
          cnt   <= LAST_KEY - 4'd1;
          state <= ROUND;
        end
        ROUND: begin
          st <= round_out;
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= LAST;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        LAST: begin
          data_out <= round_out;
          valid    <= 1'b1;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes128_inv_cipher_iter.md
Name: aes128_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher: takes one 128-bit ciphertext plus key and returns the plaintext.
- Executes one inverse round per clock cycle.
- Standalone decryption end of the AES datapath; pairs with the existing iterative cipher block so encrypt and decrypt sides run independently under a start/valid handshake.
- Holds all 11 round keys internally; a repeated key may skip re-expansion.

Parameters:
- NR, 10, number of AES rounds (fixed to 10 for AES-128; any other value is illegal).
- KEEP_KEYS, 1, 1 = key schedule is retained after completion and key reuse is honoured; 0 = key_reuse is ignored.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- key_reuse  input  1  with start: reuse the stored schedule instead of expanding key_in
- key_in  input  128  cipher key, FIPS-197 byte order (byte 0 = [127:120])
- data_in  input  128  ciphertext, same byte order
- ready  output  1  idle, able to accept start
- busy  output  1  operation in progress (equals ~ready)
- valid  output  1  one-cycle pulse: data_out holds new plaintext
- data_out  output  128  plaintext; holds its value until the next completion
- round_idx  output  4  current round-key index in use (debug); 0 in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, busy=0, valid=0, data_out=0, round_idx=0.
  - keys_valid=0 and all round-key registers cleared.
  - Reset mid-operation aborts with no valid pulse.
- FSM states: IDLE, KEXP, ARK, ROUND, LAST.
- IDLE:
  - start=1 at edge T latches data_in and key_in; rk0 <= key_in.
  - If key_reuse=1 and keys_valid=1 and KEEP_KEYS=1: data_in and the stored schedule are latched, key_in is ignored, next state is ARK.
  - Otherwise next state is KEXP and keys_valid is cleared.
- KEXP (10 cycles, edges T+1..T+10):
  - At edge T+i, rk[i] = standard expansion of rk[i-1] with Rcon[i]: RotWord, SubWord, XOR Rcon, then chained word XORs.
  - After rk10 is written, keys_valid=1 and next state is ARK.
- ARK (1 cycle): state <= ct ^ rk10; round_idx=10.
- ROUND (9 cycles): each cycle state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])), with r = 9 down to 1. round_idx shows r.
- LAST (1 cycle):
  - data_out <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0).
  - valid=1 for exactly one cycle.
  - Next state is IDLE, and ready=1 in the same cycle valid=1.
- Latency, counted from the start-sampling edge to the edge that raises valid:
  - 21 cycles with full expansion.
  - 11 cycles with key reuse.
- Back-to-back: start may be asserted in the cycle valid=1 and is accepted.
- start while busy: ignored; not queued.
- key_reuse=1 with keys_valid=0, or with KEEP_KEYS=0: treated as a full expansion (21 cycles).
- InvMixColumns coefficients {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11b.
- All byte arithmetic is XOR-only; no carries.
- data_in/key_in may change after the accepting edge without effect.

Decomposition:
- Shared package aes_pkg:
  - forward S-box function (used for key expansion).
  - inverse S-box function.
  - Rcon constant array [1..10].
  - xtime / gf_mul functions.
  - state enum {IDLE, KEXP, ARK, ROUND, LAST}.
- Sub-module aes_inv_round: combinational InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns bypassed when is_last=1. Ports: state_in, rk, is_last, state_out.
- Top holds the FSM, counter, key registers, and the rk0..rk10 array.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> valid 21 cycles after start, data_out 00112233445566778899aabbccddeeff.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
- Key reuse: after the C.1 run, start with key_reuse=1, key_in=0, same ct -> same plaintext after 11 cycles.
- Reuse without valid keys: first start after reset with key_reuse=1 -> full 21-cycle latency and correct result.
- Busy/back-to-back:
  - start pulsed during ROUND -> ignored, still only one valid.
  - start held in the valid cycle -> second result 21 cycles later.
- Reset mid-KEXP (rst_n low at cycle 5) -> outputs return to reset values, no valid pulse.
- Reset mid-KEXP, then key_reuse=1 -> full 21-cycle expansion occurs.
